// File: rtl/oh_mux5_arbiter.sv
// Round-robin, packet-locking arbiter: five valid/ready requesters share one
// registered output channel through an AND-OR one-hot mux.
module oh_mux5_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   in_valid,
  input  logic [4:0]   in_last,
  output logic [4:0]   in_ready,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  input  logic [N-1:0] in4,
  output logic         out_valid,
  output logic         out_last,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [4:0]   grant,
  output logic         locked
);

  localparam int unsigned NREQ = 5;
  localparam int unsigned PW   = 3;
  localparam int unsigned SW   = PW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic            r_locked;
  logic            r_out_valid;
  logic            r_out_last;
  logic [N-1:0]    r_out_data;

  logic            w_accept;
  logic            w_xfer;
  logic            w_sel_any;
  logic [PW-1:0]   w_sel_idx;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_ready;
  logic [N-1:0]    w_mux_data;
  logic            w_mux_last;
  logic [N-1:0]    w_in [NREQ];

  function automatic logic [NREQ-1:0] f_onehot(input logic [PW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  // (ptr + k) mod 5 for k in 0..4
  function automatic logic [PW-1:0] f_rr(input logic [PW-1:0] ptr, input int unsigned k);
    logic [SW-1:0] sum;
    sum = {1'b0, ptr} + SW'(k);
    if (sum >= SW'(NREQ)) begin
      sum = sum - SW'(NREQ);
    end
    return sum[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;
  assign w_in[4] = in4;

  // First valid requester searching from ptr with wraparound
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_sel_any && ((in_valid & f_onehot(f_rr(r_ptr, k))) != '0)) begin
        w_sel_any = 1'b1;
        w_sel_idx = f_rr(r_ptr, k);
      end
    end
  end

  // Owner is pinned while locked, even if it stalls its valid
  always_comb begin
    w_grant = '0;
    if (reset) begin
      w_grant = '0;
    end else if (r_state == ST_LOCK) begin
      w_grant = f_onehot(r_owner);
    end else if (w_sel_any) begin
      w_grant = f_onehot(w_sel_idx);
    end
  end

  assign w_accept = ~r_out_valid | out_ready;
  assign w_ready  = w_grant & {NREQ{w_accept}};
  assign w_xfer   = |(in_valid & w_ready);

  // AND-OR mux: unselected inputs are masked to zero, so X never leaks through
  always_comb begin
    w_mux_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_mux_data = w_mux_data | ({N{w_grant[i]}} & w_in[i]);
    end
    w_mux_last = |(w_grant & in_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_locked    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_last  <= w_mux_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_mux_last) begin
              r_ptr <= f_next(w_sel_idx);
            end else begin
              r_state  <= ST_LOCK;
              r_locked <= 1'b1;
              r_owner  <= w_sel_idx;
            end
          end
        end
        ST_LOCK: begin
          if (w_xfer && w_mux_last) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
            r_ptr    <= f_next(r_owner);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = w_grant;
  assign in_ready  = w_ready;
  assign locked    = r_locked;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_oh_mux5_arbiter.sv
// Directed bench for oh_mux5_arbiter with hand-computed expectations.
module tb_oh_mux5_arbiter;

  localparam int unsigned N = 32;

  logic         clk;
  logic         reset;
  logic [4:0]   in_valid;
  logic [4:0]   in_last;
  logic [4:0]   in_ready;
  logic [N-1:0] in0, in1, in2, in3, in4;
  logic         out_valid;
  logic         out_last;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic [4:0]   grant;
  logic         locked;

  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] exp_g;

  oh_mux5_arbiter #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_data (out_data),
    .out_ready(out_ready),
    .grant    (grant),
    .locked   (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic l, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_last"},  32'(out_last),  32'(l));
    chk({tag, "_data"},  out_data,       d);
  endtask

  task automatic set_data();
    in0 = 32'h10; in1 = 32'h11; in2 = 32'h12; in3 = 32'h13; in4 = 32'h14;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
    set_data();
    #2;
    chk_out("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    tick();
    reset = 1'b0;

    // 1) single beat from in2, others X
    in_valid = 5'b00100; in_last = 5'b00100; out_ready = 1'b1;
    in0 = 'x; in1 = 'x; in3 = 'x; in4 = 'x; in2 = 32'hA5;
    #1;
    chk("t1_ready", 32'(in_ready), 32'h04);
    tick();
    chk_out("t1_out", 1'b1, 1'b1, 32'hA5);
    set_data();
    in_valid = 5'b11111; in_last = 5'b11111;
    #1;
    chk("t1_ptr3", 32'(grant), 32'h08);
    tick();
    chk("t1_d3", out_data, 32'h13);
    #1;
    chk("t1_g4", 32'(grant), 32'h10);
    tick();
    chk("t1_d4", out_data, 32'h14);
    #1;
    chk("t1_wrap0", 32'(grant), 32'h01);

    // 2) all valid from reset: 0,1,2,3,4,0 back to back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_g = 5'(1 << (k % 5));
      chk("t2_grant", 32'(grant), 32'(exp_g));
      chk("t2_ready", 32'(in_ready), 32'(exp_g));
      tick();
      chk("t2_valid", 32'(out_valid), 32'h1);
      chk("t2_data", out_data, 32'h10 + 32'(k % 5));
    end

    // 3) in1 three-beat packet while in3 waits
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 5'b01010; in_last = 5'b01000; in1 = 32'hB1; in3 = 32'hC3;
    #1;
    chk("t3_g1", 32'(grant), 32'h02);
    chk("t3_l1", 32'(locked), 32'h0);
    tick();
    chk_out("t3_b1", 1'b1, 1'b0, 32'hB1);
    chk("t3_lk1", 32'(locked), 32'h1);
    in1 = 32'hB2;
    #1;
    chk("t3_g2", 32'(grant), 32'h02);
    chk("t3_r2", 32'(in_ready), 32'h02);
    tick();
    chk_out("t3_b2", 1'b1, 1'b0, 32'hB2);
    chk("t3_lk2", 32'(locked), 32'h1);
    in1 = 32'hB3; in_last = 5'b01010;
    #1;
    chk("t3_g3", 32'(grant), 32'h02);
    tick();
    chk_out("t3_b3", 1'b1, 1'b1, 32'hB3);
    chk("t3_lk3", 32'(locked), 32'h0);
    #1;
    chk("t3_g_in3", 32'(grant), 32'h08);
    chk("t3_r_in3", 32'(in_ready), 32'h08);
    tick();
    chk_out("t3_c3", 1'b1, 1'b1, 32'hC3);

    // 4) owner stalls mid-packet; lock must hold, stray in_last ignored
    in1 = 32'hD1; in_last = 5'b01000; in_valid = 5'b01010;
    #1;
    chk("t4_g1", 32'(grant), 32'h02);
    tick();
    chk_out("t4_d1", 1'b1, 1'b0, 32'hD1);
    in_valid = 5'b01000; in_last = 5'b01010;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t4_stall_g", 32'(grant), 32'h02);
      chk("t4_stall_r", 32'(in_ready), 32'h02);
      tick();
      chk("t4_stall_v", 32'(out_valid), 32'h0);
      chk("t4_stall_lk", 32'(locked), 32'h1);
    end
    in_valid = 5'b01010; in1 = 32'hD2;
    #1;
    chk("t4_g2", 32'(grant), 32'h02);
    tick();
    chk_out("t4_d2", 1'b1, 1'b1, 32'hD2);
    chk("t4_lk_end", 32'(locked), 32'h0);

    // 5) output backpressure with all inputs valid
    set_data();
    in_valid = 5'b11111; in_last = 5'b11111;
    #1;
    chk("t5_g2", 32'(grant), 32'h04);
    tick();
    chk_out("t5_x2", 1'b1, 1'b1, 32'h12);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_bp_g", 32'(grant), 32'h08);
      chk("t5_bp_r", 32'(in_ready), 32'h00);
      tick();
      chk_out("t5_bp", 1'b1, 1'b1, 32'h12);
    end
    in_valid = 5'b10000;
    #1;
    chk("t5_reeval_g", 32'(grant), 32'h10);
    chk("t5_reeval_r", 32'(in_ready), 32'h00);
    tick();
    chk("t5_reeval_d", out_data, 32'h12);
    in_valid = 5'b11111; out_ready = 1'b1;
    #1;
    chk("t5_res_r", 32'(in_ready), 32'h08);
    tick();
    chk_out("t5_res", 1'b1, 1'b1, 32'h13);

    // 6) async reset while locked with a held beat
    in_valid = 5'b00001; in_last = 5'b00000; in0 = 32'hE0;
    #1;
    chk("t6_g0", 32'(grant), 32'h01);
    tick();
    chk_out("t6_e0", 1'b1, 1'b0, 32'hE0);
    chk("t6_lk", 32'(locked), 32'h1);
    reset = 1'b1;
    #1;
    chk_out("t6_rst", 1'b0, 1'b0, 32'h0);
    chk("t6_rst_lk", 32'(locked), 32'h0);
    chk("t6_rst_g", 32'(grant), 32'h0);
    chk("t6_rst_r", 32'(in_ready), 32'h0);
    tick();
    reset = 1'b0;
    in_valid = 5'b10010; in_last = 5'b11111;
    #1;
    chk("t6_ptr0", 32'(grant), 32'h02);
    tick();
    chk_out("t6_after", 1'b1, 1'b1, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
